// File: rtl/alu_seq.sv
// Sequencer that drives an external registered ALU one operation at a time.
// It accepts a request, steps the ALU through load/execute, then holds the result and flags for the consumer.
module alu_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    input  logic [2:0] req_shamt,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [3:0] rsp_flags,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_op,
    output logic [2:0] alu_shamt,
    input  logic [7:0] alu_out
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_ORR = 3'd3;
    localparam logic [2:0] OP_EOR = 3'd4;
    localparam logic [2:0] OP_NEG = 3'd5;
    localparam logic [2:0] OP_LSL = 3'd6;
    localparam logic [2:0] OP_LSR = 3'd7;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        EXEC = 3'd2,
        CAPT = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] op_q;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic [2:0] shamt_q;
    logic [7:0] rsp_data_q;
    logic [3:0] rsp_flags_q;
    logic [3:0] flags_d;
    logic [2:0] lsl_idx;
    logic [2:0] lsr_idx;

    // NOTE: non-blocking assignments for every register so all state updates together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= OP_ADD;
            a_q         <= 8'h00;
            b_q         <= 8'h00;
            shamt_q     <= 3'd0;
            rsp_data_q  <= 8'h00;
            rsp_flags_q <= 4'h0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid) begin
                op_q    <= req_op;
                a_q     <= req_a;
                b_q     <= req_b;
                shamt_q <= req_shamt;
            end
            if (state_q == CAPT) begin
                rsp_data_q  <= alu_out;
                rsp_flags_q <= flags_d;
            end
        end
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        alu_op    = OP_LSL;
        alu_shamt = 3'd0;
        alu_a     = 8'h00;
        alu_b     = 8'h00;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = (req_op == OP_LSL || req_op == OP_LSR) ? LOAD : EXEC;
                end
            end
            LOAD: begin
                alu_op  = OP_ORR;
                alu_a   = a_q;
                state_d = EXEC;
            end
            EXEC: begin
                alu_op    = op_q;
                alu_a     = a_q;
                alu_b     = b_q;
                alu_shamt = shamt_q;
                state_d   = CAPT;
            end
            CAPT: state_d = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Shift carry is the last bit shifted out of the original operand.
    assign lsl_idx = 3'(4'd8 - {1'b0, shamt_q});
    assign lsr_idx = shamt_q - 3'd1;

    always_comb begin
        flags_d    = 4'h0;
        flags_d[3] = alu_out[7];
        flags_d[2] = (alu_out == 8'h00);
        case (op_q)
            OP_ADD: begin
                flags_d[1] = (({1'b0, a_q} + {1'b0, b_q}) >= 9'd256);
                flags_d[0] = (a_q[7] == b_q[7]) && (alu_out[7] != a_q[7]);
            end
            OP_SUB: begin
                flags_d[1] = (a_q >= b_q);
                flags_d[0] = (a_q[7] != b_q[7]) && (alu_out[7] != a_q[7]);
            end
            OP_LSL: flags_d[1] = (shamt_q != 3'd0) && a_q[lsl_idx];
            OP_LSR: flags_d[1] = (shamt_q != 3'd0) && a_q[lsr_idx];
            default: ;
        endcase
    end

    assign rsp_data  = rsp_data_q;
    assign rsp_flags = rsp_flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural registered ALU attached to its ALU port.
// Checks reset values, per-op results/flags, latency, response hold and reset abort.
module tb_alu_seq;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_ORR = 3'd3;
    localparam logic [2:0] OP_EOR = 3'd4;
    localparam logic [2:0] OP_NEG = 3'd5;
    localparam logic [2:0] OP_LSL = 3'd6;
    localparam logic [2:0] OP_LSR = 3'd7;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [2:0] req_shamt;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [3:0] rsp_flags;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_op;
    logic [2:0] alu_shamt;
    logic [7:0] alu_q;

    int errors = 0;
    int checks = 0;

    alu_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_shamt (req_shamt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_flags (rsp_flags),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_shamt (alu_shamt),
        .alu_out   (alu_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ALU without reset; shifts act on its own register, so LSL by 0 holds.
    always @(posedge clk) begin
        case (alu_op)
            OP_ADD:  alu_q <= alu_a + alu_b;
            OP_SUB:  alu_q <= alu_a - alu_b;
            OP_AND:  alu_q <= alu_a & alu_b;
            OP_ORR:  alu_q <= alu_a | alu_b;
            OP_EOR:  alu_q <= alu_a ^ alu_b;
            OP_NEG:  alu_q <= ~alu_b;
            OP_LSL:  alu_q <= alu_q << alu_shamt;
            default: alu_q <= alu_q >> alu_shamt;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_data"}, rsp_data, 8'h00);
        check({tag, "_rsp_flags"}, rsp_flags, 4'h0);
        check({tag, "_alu_op"}, alu_op, OP_LSL);
        check({tag, "_alu_shamt"}, alu_shamt, 0);
        check({tag, "_alu_a"}, alu_a, 8'h00);
        check({tag, "_alu_b"}, alu_b, 8'h00);
    endtask

    // Called at a negedge in IDLE; returns at a negedge in IDLE.
    // A nonzero hold keeps rsp_ready low that many RESP cycles and leaves an ORR 0x0F|0xF0 request pending.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] sh, input logic [7:0] exp_d, input logic [3:0] exp_f,
                          input int hold);
        int  lat;
        bit  shift;
        shift     = (op == OP_LSL) || (op == OP_LSR);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_shamt = sh;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        check({tag, "_req_ready"}, req_ready, 1);
        @(posedge clk); lat = 1; @(negedge clk);
        req_valid = 1'b0;
        check({tag, "_alu_op1"}, alu_op, shift ? OP_ORR : op);
        check({tag, "_alu_a1"}, alu_a, a);
        check({tag, "_alu_b1"}, alu_b, shift ? 8'h00 : b);
        @(posedge clk); lat = 2; @(negedge clk);
        check({tag, "_alu_op2"}, alu_op, shift ? op : OP_LSL);
        if (shift) check({tag, "_alu_shamt2"}, alu_shamt, sh);
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        check({tag, "_latency"}, lat, shift ? 4 : 3);
        check({tag, "_data"}, rsp_data, exp_d);
        check({tag, "_flags"}, rsp_flags, exp_f);
        for (int i = 0; i < hold; i++) begin
            if (i == 0) begin
                req_op    = OP_ORR;
                req_a     = 8'h0F;
                req_b     = 8'hF0;
                req_shamt = 3'd0;
                req_valid = 1'b1;
            end
            @(posedge clk); @(negedge clk);
            check({tag, "_hold_valid"}, rsp_valid, 1);
            check({tag, "_hold_data"}, rsp_data, exp_d);
            check({tag, "_hold_flags"}, rsp_flags, exp_f);
            check({tag, "_hold_req_ready"}, req_ready, 0);
            check({tag, "_hold_alu_op"}, alu_op, OP_LSL);
            check({tag, "_hold_alu_shamt"}, alu_shamt, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_done_valid"}, rsp_valid, 0);
        check({tag, "_done_req_ready"}, req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = OP_ADD;
        req_a     = 8'h00;
        req_b     = 8'h00;
        req_shamt = 3'd0;
        rsp_ready = 1'b0;
        alu_q     = 8'h5A;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // rsp_ready while idle must not change anything.
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("idle_rsp_ready_valid", rsp_valid, 0);
        check("idle_rsp_ready_ready", req_ready, 1);

        run_op("add_ovf",  OP_ADD, 8'h7F, 8'h01, 3'd0, 8'h80, 4'b1001, 0);
        run_op("sub_eq",   OP_SUB, 8'h05, 8'h05, 3'd0, 8'h00, 4'b0110, 0);
        run_op("sub_brw",  OP_SUB, 8'h00, 8'h01, 3'd0, 8'hFF, 4'b1000, 0);
        run_op("lsl_1",    OP_LSL, 8'h81, 8'h00, 3'd1, 8'h02, 4'b0010, 0);
        run_op("lsr_1",    OP_LSR, 8'h01, 8'h00, 3'd1, 8'h00, 4'b0110, 0);
        run_op("neg_0",    OP_NEG, 8'h55, 8'h00, 3'd0, 8'hFF, 4'b1000, 0);
        run_op("add_cz",   OP_ADD, 8'hFF, 8'h01, 3'd0, 8'h00, 4'b0110, 5);
        run_op("orr_pend", OP_ORR, 8'h0F, 8'hF0, 3'd0, 8'hFF, 4'b1000, 0);
        run_op("and",      OP_AND, 8'hF0, 8'h3C, 3'd0, 8'h30, 4'b0000, 0);
        run_op("lsl_0",    OP_LSL, 8'h80, 8'h00, 3'd0, 8'h80, 4'b1000, 0);
        run_op("lsr_7",    OP_LSR, 8'hC0, 8'h00, 3'd7, 8'h01, 4'b0010, 0);
        run_op("lsl_7",    OP_LSL, 8'h03, 8'h00, 3'd7, 8'h80, 4'b1010, 0);
        run_op("sub_ovf",  OP_SUB, 8'h80, 8'h01, 3'd0, 8'h7F, 4'b0011, 0);

        // Abort a transaction in EXEC with reset.
        req_op    = OP_ADD;
        req_a     = 8'h10;
        req_b     = 8'h20;
        req_shamt = 3'd0;
        req_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        check("abort_in_exec", alu_op, OP_ADD);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(posedge clk); @(negedge clk);
        check("abort_no_rsp", rsp_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("eor_post", OP_EOR, 8'hF0, 8'hFF, 3'd0, 8'h0F, 4'b0000, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 8-bit data, 3-bit op, 3-bit shift amount, 4-bit flags.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  reset; SHALL be asynchronous and active-low.
REQ-004 req_valid  in  1  request present.
REQ-005 req_ready  out  1  block can accept a request.
REQ-006 req_op  in  3  operation, ALU_OP_* encodings from alu.vh.
REQ-007 req_a, req_b  in  8 each  operands.
REQ-008 req_shamt  in  3  shift amount for LSL/LSR.
REQ-009 rsp_valid  out  1  response present.
REQ-010 rsp_ready  in  1  consumer accepts response.
REQ-011 rsp_data  out  8  result.
REQ-012 rsp_flags  out  4  {N,Z,C,V}, bit 3 = N.
REQ-013 alu_a, alu_b  out  8 each  ALU operands.
REQ-014 alu_op  out  3  ALU opcode.
REQ-015 alu_shamt  out  3  ALU shift amount.
REQ-016 alu_out  in  8  registered ALU result, valid one clk after its inputs are driven.

Function
REQ-017 States SHALL be IDLE, LOAD, EXEC, CAPT, RESP; req_ready = 1 only in IDLE.
REQ-018 IDLE: on req_valid && req_ready, latch req_op/a/b/shamt; next state LOAD for LSL/LSR, else EXEC.
REQ-019 LOAD: drive alu_op=ORR, alu_a=latched a, alu_b=0x00, so the ALU register holds a; next EXEC.
REQ-020 EXEC: drive alu_op=latched op, alu_a/alu_b=latched a/b, alu_shamt=latched shamt; next CAPT.
REQ-021 CAPT: register alu_out into rsp_data and computed flags into rsp_flags at the closing edge; next RESP.
REQ-022 RESP: rsp_valid = 1; rsp_data/rsp_flags stable; on rsp_ready go IDLE at that edge.
REQ-023 Latency acceptance edge to rsp_valid high SHALL be 3 cycles (non-shift) and 4 cycles (LSL/LSR).
REQ-024 In IDLE, CAPT, RESP the block SHALL drive alu_op=LSL, alu_shamt=0 (ALU holds its register); alu_a/alu_b SHALL be 0 in these states.
REQ-025 N = result[7]; Z = (result == 0x00) for all ops.
REQ-026 ADD: C = carry out of 9-bit a+b; V = (a[7]==b[7]) && (result[7]!=a[7]).
REQ-027 SUB: C = 1 when a >= b unsigned (no borrow); V = (a[7]!=b[7]) && (result[7]!=a[7]).
REQ-028 LSL: C = a[8-shamt] if shamt != 0 else 0; LSR: C = a[shamt-1] if shamt != 0 else 0; V = 0.
REQ-029 NEG, AND, ORR, EOR: C = 0, V = 0.
REQ-030 Request inputs outside IDLE SHALL be ignored; no overlap of transactions; req_valid held through RESP SHALL be accepted in the first IDLE cycle after.
REQ-031 rsp_ready while rsp_valid = 0 SHALL have no effect.
REQ-032 Block SHALL not rely on alu_out except in CAPT (ALU has no reset).

Reset
REQ-033 While rst_n = 0: state IDLE, req_ready = 1, rsp_valid = 0, rsp_data = 0x00, rsp_flags = 0x0, alu_op = LSL, alu_shamt = 0, alu_a = alu_b = 0x00.
REQ-034 Reset asserted mid-transaction SHALL abort it immediately with no response; first request after release SHALL complete normally.

Verification
REQ-035 ADD a=0x7F b=0x01 -> rsp_data 0x80, flags 4'b1001, rsp_valid 3 cycles after acceptance.
REQ-036 SUB a=0x05 b=0x05 -> rsp_data 0x00, flags 4'b0110; SUB a=0x00 b=0x01 -> 0xFF, flags 4'b1000.
REQ-037 LSL a=0x81 shamt=1 -> alu_op sequence ORR, LSL, rsp_data 0x02, flags 4'b0010, latency 4; LSR a=0x01 shamt=1 -> 0x00, flags 4'b0110.
REQ-038 NEG b=0x00 -> rsp_data 0xFF, flags 4'b1000.
REQ-039 rsp_ready low 5 cycles in RESP -> rsp_valid, rsp_data, rsp_flags constant, req_ready 0, alu_op = LSL/shamt 0 throughout; completes on first rsp_ready.
REQ-040 rst_n low during EXEC -> all outputs at REQ-033 values before next edge; post-release EOR a=0xF0 b=0xFF -> 0x0F, flags 4'b0000.
